cla_operand_stage: RTL and testbench

CLA_OPERAND_STAGE -- requirements
Module: cla_operand_stage

---
 rtl/cla_operand_stage.sv | 99 +++++++++
 tb/tb_cla_operand_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_operand_stage.sv
// Operand staging for a downstream carry-lookahead adder: 2-entry FIFO in, registered {carry,sum} out.
// Optional 16-bit saturating carry-out counter when CLA_STAGE_OVF_CNT_EN is defined.
module cla_operand_stage #(
  parameter int WIDTH = 46
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_add1,
  output logic [WIDTH-1:0] o_add2,
  input  logic [WIDTH:0]   i_result,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_carry
`ifdef CLA_STAGE_OVF_CNT_EN
  ,
  output logic [15:0]      o_ovf_count
`endif
);

  logic [WIDTH-1:0] a_q [2];
  logic [WIDTH-1:0] b_q [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             rdy_en;
  logic             push;
  logic             pop;
  logic             not_empty;

  assign not_empty = (count != 2'd0);
  assign o_ready   = rdy_en && (count < 2'd2);
  assign push      = i_valid && o_ready;
  assign pop       = not_empty && (!o_valid || i_ready);

  assign o_add1  = not_empty ? a_q[rd_ptr] : '0;
  assign o_add2  = not_empty ? b_q[rd_ptr] : '0;
  assign o_carry = o_result[WIDTH];

  // Hold o_ready low in reset and for the release cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q[0] <= '0;
      a_q[1] <= '0;
      b_q[0] <= '0;
      b_q[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        a_q[wr_ptr] <= i_a;
        b_q[wr_ptr] <= i_b;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Output register: load on pop, hold under backpressure, drop after handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_result <= '0;
    end else if (pop) begin
      o_valid  <= 1'b1;
      o_result <= i_result;
    end else if (i_ready) begin
      o_valid  <= 1'b0;
    end
  end

`ifdef CLA_STAGE_OVF_CNT_EN
  // Count loads that carried out, saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf_count <= 16'd0;
    end else if (pop && i_result[WIDTH] && (o_ovf_count != 16'hFFFF)) begin
      o_ovf_count <= o_ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cla_operand_stage.sv
// Directed self-checking bench for cla_operand_stage.
// Models the downstream adder combinationally from o_add1/o_add2.
module tb_cla_operand_stage;

  localparam int W = 46;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic [W-1:0] o_add1;
  logic [W-1:0] o_add2;
  logic [W:0]   i_result;
  logic         o_valid;
  logic         i_ready;
  logic [W:0]   o_result;
  logic         o_carry;
`ifdef CLA_STAGE_OVF_CNT_EN
  logic [15:0]  o_ovf_count;
`endif

  int pass_cnt = 0;
  int total    = 0;

  assign i_result = {1'b0, o_add1} + {1'b0, o_add2};

  cla_operand_stage #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_add1   (o_add1),
    .o_add2   (o_add2),
    .i_result (i_result),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_carry  (o_carry)
`ifdef CLA_STAGE_OVF_CNT_EN
    ,
    .o_ovf_count (o_ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_a = '0;
    i_b = '0;
    #2;
    total++;
    if ({o_valid, o_ready, o_result, o_add1, o_add2} !== '0)
      $display("FAIL reset_outs: got v=%b r=%b res=%h a1=%h a2=%h want all 0",
               o_valid, o_ready, o_result, o_add1, o_add2);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (o_ready !== 1'b0)
      $display("FAIL ready_before_edge: got %b want 0", o_ready);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL ready_after_edge: got r=%b v=%b want r=1 v=0",
               o_ready, o_valid);
    else pass_cnt++;
  endtask

  task automatic test_single();
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_a = 46'h1;
    i_b = 46'h2;
    @(negedge clk);
    i_valid = 1'b0;
    total++;
    if (o_valid !== 1'b0)
      $display("FAIL single_early: o_valid got %b want 0", o_valid);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_result !== 47'h3 || o_carry !== 1'b0)
      $display("FAIL single_result: got v=%b res=%h c=%b want v=1 res=3 c=0",
               o_valid, o_result, o_carry);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0)
      $display("FAIL single_drop: o_valid got %b want 0", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_carry();
    i_valid = 1'b1;
    i_a = 46'h3FFF_FFFF_FFFF;
    i_b = 46'h3FFF_FFFF_FFFF;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_result !== 47'h7FFF_FFFF_FFFE || o_carry !== 1'b1)
      $display("FAIL carry_result: got v=%b res=%h c=%b want v=1 res=7ffffffffffe c=1",
               o_valid, o_result, o_carry);
    else pass_cnt++;
`ifdef CLA_STAGE_OVF_CNT_EN
    total++;
    if (o_ovf_count !== 16'd1)
      $display("FAIL ovf_count: got %0d want 1", o_ovf_count);
    else pass_cnt++;
`endif
    @(negedge clk);
  endtask

  task automatic fill_three();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_a = 46'd1;
    i_b = 46'd1;
    @(negedge clk);
    i_a = 46'd2;
    i_b = 46'd2;
    @(negedge clk);
    i_a = 46'd3;
    i_b = 46'd3;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    fill_three();
    total++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== 47'd2)
      $display("FAIL bp_full: got r=%b v=%b res=%0d want r=0 v=1 res=2",
               o_ready, o_valid, o_result);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== 47'd2)
      $display("FAIL bp_hold: got r=%b v=%b res=%0d want r=0 v=1 res=2",
               o_ready, o_valid, o_result);
    else pass_cnt++;
    i_ready = 1'b1;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_result !== 47'd4)
      $display("FAIL bp_second: got v=%b res=%0d want v=1 res=4",
               o_valid, o_result);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_result !== 47'd6 || o_ready !== 1'b1)
      $display("FAIL bp_third: got v=%b res=%0d r=%b want v=1 res=6 r=1",
               o_valid, o_result, o_ready);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0)
      $display("FAIL bp_drain: o_valid got %b want 0", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp_q[$];
    logic [W:0] exp_v;
    int got = 0;
    int gaps = 0;
    int cyc = 0;
    i_ready = 1'b1;
    while (got < 100 && cyc < 300) begin
      if (cyc < 100) begin
        i_valid = 1'b1;
        i_a = {$urandom, $urandom};
        i_b = {$urandom, $urandom};
        if (cyc < 3) begin
          i_a = '1;
          i_b = 46'd1 << cyc;
        end
        exp_q.push_back({1'b0, i_a} + {1'b0, i_b});
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (cyc < 100 && o_ready !== 1'b1) gaps++;
      if (o_valid === 1'b1) begin
        exp_v = exp_q.pop_front();
        got++;
        total++;
        if (o_result !== exp_v || o_carry !== exp_v[W])
          $display("FAIL stream_%0d: got %h want %h", got, o_result, exp_v);
        else pass_cnt++;
      end else if (got > 0) begin
        gaps++;
      end
    end
    i_valid = 1'b0;
    total++;
    if (got != 100 || gaps != 0 || cyc != 101)
      $display("FAIL stream_rate: got results=%0d gaps=%0d cycles=%0d want 100 0 101",
               got, gaps, cyc);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    fill_three();
    total++;
    if (o_valid !== 1'b1 || o_ready !== 1'b0)
      $display("FAIL mid_pre: got v=%b r=%b want v=1 r=0", o_valid, o_ready);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_valid, o_ready, o_result, o_add1, o_add2, o_carry} !== '0)
      $display("FAIL mid_reset: got v=%b r=%b res=%h a1=%h a2=%h want all 0",
               o_valid, o_ready, o_result, o_add1, o_add2);
    else pass_cnt++;
`ifdef CLA_STAGE_OVF_CNT_EN
    total++;
    if (o_ovf_count !== 16'd0)
      $display("FAIL mid_ovf: got %0d want 0", o_ovf_count);
    else pass_cnt++;
`endif
    @(negedge clk);
    i_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_add1 !== '0)
      $display("FAIL mid_release: got r=%b v=%b a1=%h want r=1 v=0 a1=0",
               o_ready, o_valid, o_add1);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0)
      $display("FAIL mid_quiet: o_valid got %b want 0", o_valid);
    else pass_cnt++;
    i_valid = 1'b1;
    i_a = 46'd5;
    i_b = 46'd7;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_result !== 47'd12)
      $display("FAIL mid_new: got v=%b res=%0d want v=1 res=12", o_valid, o_result);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
